geofence_driver: RTL and testbench

GEOFENCE_DRIVER -- requirements
Module: geofence_driver

---
 rtl/geofence_driver_if.sv | 28 ++
 rtl/geofence_driver.sv | 185 ++++++++++++++++++
 tb/tb_geofence_driver.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/geofence_driver_if.sv
// Bus bundle between the geofence driver, its point memory, the geofence engine and the job host.
// The driver uses the master view; the environment uses the slave view.
interface geofence_driver_if;
  logic        start;
  logic [3:0]  num_obj;
  logic [6:0]  mem_addr;
  logic [19:0] mem_data;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        xy_vld;
  logic        valid;
  logic        is_inside;
  logic        busy;
  logic        done;
  logic [14:0] result_vec;
  logic [3:0]  inside_cnt;
  logic        timeout_err;

  modport master (
    input  start, num_obj, mem_data, valid, is_inside,
    output mem_addr, X, Y, xy_vld, busy, done, result_vec, inside_cnt, timeout_err
  );

  modport slave (
    output start, num_obj, mem_data, valid, is_inside,
    input  mem_addr, X, Y, xy_vld, busy, done, result_vec, inside_cnt, timeout_err
  );
endinterface

// File: rtl/geofence_driver.sv
// Streams 7-point objects (test point + 6 fence vertices) from point memory to a geofence engine
// and collects one inside/outside result per object. Define GEOFENCE_DRIVER_TIMEOUT_EN for a WAIT timeout.
//
// state    | meaning
// IDLE     | waiting for start
// PREFETCH | first test point addressed, data lands next cycle
// SEND     | 7 points on X/Y, address one ahead
// WAIT     | waiting for engine result, next test point already addressed
// FINISH   | one-cycle done pulse
module geofence_driver (
  input  logic              clk,
  input  logic              reset,
  geofence_driver_if.master bus
);

  typedef enum logic [2:0] {IDLE, PREFETCH, SEND, WAIT, FINISH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  num_q, num_d;
  logic [3:0]  obj_q, obj_d;
  logic [2:0]  pt_q, pt_d;
  logic [6:0]  base_q, base_d;
  logic [6:0]  addr_q, addr_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [14:0] rv_q, rv_d;
  logic [3:0]  cnt_q, cnt_d;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
  logic        tmo_q, tmo_d;
  logic [5:0]  wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    obj_d   = obj_q;
    pt_d    = pt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    x_d     = '0;
    y_d     = '0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    rv_d    = rv_q;
    cnt_d   = cnt_q;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_obj != 4'd0) begin
            state_d = PREFETCH;
            num_d   = bus.num_obj;
            obj_d   = '0;
            base_d  = '0;
            addr_d  = '0;
            rv_d    = '0;
            cnt_d   = '0;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      PREFETCH: begin
        state_d = SEND;
        pt_d    = '0;
        x_d     = bus.mem_data[19:10];
        y_d     = bus.mem_data[9:0];
        vld_d   = 1'b1;
        addr_d  = base_q + 7'd1;
      end
      SEND: begin
        if (pt_q == 3'd6) begin
          state_d = WAIT;
          addr_d  = base_q + 7'd7;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else begin
          pt_d   = pt_q + 3'd1;
          x_d    = bus.mem_data[19:10];
          y_d    = bus.mem_data[9:0];
          vld_d  = 1'b1;
          addr_d = base_q + {4'd0, pt_q} + 7'd2;
        end
      end
      WAIT: begin
        if (bus.valid) begin
          rv_d   = rv_q | ({14'd0, bus.is_inside} << obj_q);
          cnt_d  = cnt_q + {3'd0, bus.is_inside};
          obj_d  = obj_q + 4'd1;
          base_d = base_q + 7'd7;
          if (obj_q == num_q - 4'd1) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            // next test point was addressed during WAIT, so it is on mem_data now
            state_d = SEND;
            pt_d    = '0;
            x_d     = bus.mem_data[19:10];
            y_d     = bus.mem_data[9:0];
            vld_d   = 1'b1;
            addr_d  = base_q + 7'd8;
          end
        end
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
        else if (wcnt_q == 6'd62) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 6'd1;
        end
`endif
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      obj_q   <= '0;
      pt_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= '0;
      cnt_q   <= '0;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      obj_q   <= obj_d;
      pt_q    <= pt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.xy_vld     = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_vec = rv_q;
  assign bus.inside_cnt = cnt_q;
`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: expected per-cycle traces are built from the job description
// (object count, results, WAIT lengths, memory contents) and compared cycle by cycle.
module tb_geofence_driver;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  geofence_driver_if bus();
  geofence_driver dut (.clk(clk), .reset(reset), .bus(bus));

  logic [19:0] mem [0:127];
  assign bus.mem_data = mem[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  logic [6:0]  last_addr;
  logic [14:0] m_rv;
  logic [3:0]  m_cnt;
  int          wl [0:14];

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vld;
    logic [6:0] addr;
    logic       done;
    logic       busy;
    logic       val;
    logic       ins;
    logic       quiet;
  } cyc_t;
  cyc_t plan [$];

  typedef struct {
    int          n;
    logic [14:0] pat;
    int          wait_len;
    logic [14:0] exp_rv;
    logic [3:0]  exp_cnt;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace: PREFETCH, then per object 7 points and its WAIT cycles, then FINISH and IDLE.
  task automatic run_job(input int n, input logic [14:0] pat, input bit noise);
    cyc_t e;
    plan.delete();
    if (n > 0) begin
      e = '0; e.busy = 1'b1; plan.push_back(e);
      for (int o = 0; o < n; o++) begin
        for (int k = 0; k < 7; k++) begin
          e = '0; e.busy = 1'b1; e.vld = 1'b1;
          e.x = mem[7*o+k][19:10];
          e.y = mem[7*o+k][9:0];
          e.addr = 7'(7*o + k + 1);
          plan.push_back(e);
        end
        for (int w = 1; w <= wl[o]; w++) begin
          e = '0; e.busy = 1'b1; e.quiet = 1'b1;
          e.addr = 7'(7*o + 7);
          e.val = (w == wl[o]);
          e.ins = pat[o];
          plan.push_back(e);
        end
      end
      last_addr = 7'(7*n);
      m_rv = '0;
      m_cnt = '0;
      for (int o = 0; o < n; o++) begin
        m_rv[o] = pat[o];
        m_cnt = m_cnt + 4'(pat[o]);
      end
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.addr = last_addr; plan.push_back(e);
    e = '0; e.addr = last_addr; e.quiet = 1'b1; plan.push_back(e);

    bus.start = 1'b1;
    bus.num_obj = 4'(n);
    tick();
    bus.start = 1'b0;
    foreach (plan[i]) begin
      chk("X", 32'(bus.X), 32'(plan[i].x));
      chk("Y", 32'(bus.Y), 32'(plan[i].y));
      chk("xy_vld", 32'(bus.xy_vld), 32'(plan[i].vld));
      chk("mem_addr", 32'(bus.mem_addr), 32'(plan[i].addr));
      chk("done", 32'(bus.done), 32'(plan[i].done));
      chk("busy", 32'(bus.busy), 32'(plan[i].busy));
      bus.valid = plan[i].val;
      bus.is_inside = plan[i].ins;
      bus.start = 1'b0;
      if (noise && plan[i].busy) begin
        if (!plan[i].quiet && $urandom_range(0, 3) == 0) begin
          bus.valid = 1'b1;
          bus.is_inside = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 5) == 0) begin
          bus.start = 1'b1;
          bus.num_obj = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end
    bus.valid = 1'b0;
    bus.is_inside = 1'b0;
    bus.start = 1'b0;
    chk("result_vec", 32'(bus.result_vec), 32'(m_rv));
    chk("inside_cnt", 32'(bus.inside_cnt), 32'(m_cnt));
    chk("timeout_err", 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_X"}, 32'(bus.X), 32'd0);
    chk({tag, "_Y"}, 32'(bus.Y), 32'd0);
    chk({tag, "_xy_vld"}, 32'(bus.xy_vld), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_result_vec"}, 32'(bus.result_vec), 32'd0);
    chk({tag, "_inside_cnt"}, 32'(bus.inside_cnt), 32'd0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_obj = '0;
    bus.valid = 1'b0;
    bus.is_inside = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 20'($urandom);
    last_addr = '0;
    m_rv = '0;
    m_cnt = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // empty job: done next cycle, no memory access
    run_job(0, 15'd0, 1'b0);

    // object 0: test point (5,5) inside a hexagon
    mem[0] = {10'd5, 10'd5};
    mem[1] = {10'd8, 10'd5};
    mem[2] = {10'd7, 10'd8};
    mem[3] = {10'd3, 10'd8};
    mem[4] = {10'd2, 10'd5};
    mem[5] = {10'd3, 10'd2};
    mem[6] = {10'd7, 10'd2};

    tbl[0] = '{1,  15'h0001, 4, 15'h0001, 4'd1};
    tbl[1] = '{3,  15'h0005, 3, 15'h0005, 4'd2};
    tbl[2] = '{15, 15'h7FFF, 1, 15'h7FFF, 4'd15};
    tbl[3] = '{15, 15'h2AAA, 2, 15'h2AAA, 4'd7};
    tbl[4] = '{2,  15'h7FFE, 5, 15'h0002, 4'd1};
    for (int t = 0; t < 5; t++) begin
      for (int o = 0; o < 15; o++) wl[o] = tbl[t].wait_len;
      run_job(tbl[t].n, tbl[t].pat, t == 1);
      chk("tbl_result_vec", 32'(bus.result_vec), 32'(tbl[t].exp_rv));
      chk("tbl_inside_cnt", 32'(bus.inside_cnt), 32'(tbl[t].exp_cnt));
    end

    // reset in the middle of SEND, together with start and valid
    bus.start = 1'b1;
    bus.num_obj = 4'd2;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("pt3_X", 32'(bus.X), 32'(mem[3][19:10]));
    chk("pt3_addr", 32'(bus.mem_addr), 32'd4);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.num_obj = 4'd5;
    bus.valid = 1'b1;
    bus.is_inside = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.valid = 1'b0;
    bus.is_inside = 1'b0;
    chk_reset_vals("midrst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_no_done", 32'(bus.done), 32'd0);
      chk("midrst_idle", 32'(bus.busy), 32'd0);
    end
    last_addr = '0;
    m_rv = '0;
    m_cnt = '0;
    for (int o = 0; o < 15; o++) wl[o] = 2;
    run_job(2, 15'h0003, 1'b0);

`ifdef GEOFENCE_DRIVER_TIMEOUT_EN
    begin
      int wc;
      bus.start = 1'b1;
      bus.num_obj = 4'd2;
      tick();
      bus.start = 1'b0;
      repeat (8) tick();
      chk("tmo_wait_vld", 32'(bus.xy_vld), 32'd0);
      wc = 0;
      while (!bus.done && wc < 200) begin
        wc++;
        tick();
      end
      chk("tmo_wait_cycles", 32'(wc), 32'd63);
      chk("tmo_done", 32'(bus.done), 32'd1);
      chk("tmo_err", 32'(bus.timeout_err), 32'd1);
      chk("tmo_result_vec", 32'(bus.result_vec), 32'd0);
      tick();
      chk("tmo_idle", 32'(bus.busy), 32'd0);
      last_addr = 7'd7;
      m_rv = '0;
      m_cnt = '0;
    end
`endif

    // randomized jobs with ignored valid/start noise
    for (int j = 0; j < 25; j++) begin
      int n;
      logic [14:0] pat;
      for (int i = 0; i < 128; i++) mem[i] = 20'($urandom);
      n = (j % 8 == 7) ? 0 : $urandom_range(1, 15);
      pat = 15'($urandom);
      for (int o = 0; o < 15; o++) wl[o] = $urandom_range(1, 8);
      run_job(n, pat, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
